led_matrix_scroller: RTL
========================

Name: led_matrix_scroller

Overview:
- Parametrised successor of the fixed 5x7 column-scanned LED panel.
- Holds a message of MSG_COLS columns in a writable buffer and shows a COLS-wide window of it on a ROWS x COLS multiplexed matrix.
- The window scrolls left or right with wrap-around at a programmable rate, or holds, or blanks.
- Replaces the fixed shift-register rows, the hard-wired pattern constants and the separate divider/counter/decoder chain.

Parameters:
- ROWS, 5, LEDs per column (row bus width).
- COLS, 7, visible columns; one-hot column select width.
- MSG_COLS, 16, message buffer depth in columns; must be >= COLS.
- SCAN_DIV, 1000, clk cycles per column dwell; must be >= 2.
- SCROLL_FRAMES, 50, full frames per scroll step; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  00 hold, 01 scroll left, 10 scroll right, 11 blank
- wr_en  in  1  message buffer write strobe
- wr_addr  in  clog2(MSG_COLS)  buffer column to write
- wr_data  in  ROWS  column pattern, bit i drives row i
- row  out  ROWS  row drive for the active column, active-high
- col_sel  out  COLS  one-hot active-high column enable
- frame_start  out  1  one-cycle pulse when column 0 becomes active
- offset  out  clog2(MSG_COLS)  buffer column currently shown in display column 0

Behaviour:
- Reset (rst_n low, asynchronous): buffer cleared to 0; scan counter, column index, frame counter and offset set to 0; row=0, col_sel=0, frame_start=0.
- Scan prescaler: counts 0..SCAN_DIV-1. At terminal count it wraps and col_idx advances by 1, wrapping at COLS-1 -> 0.
- Outputs are registered and update in the cycle after col_idx changes:
  - col_sel = one-hot(col_idx).
  - row = buf[(offset + col_idx) mod MSG_COLS].
  - The modulo is computed without a divider: add, then subtract MSG_COLS if the sum is >= MSG_COLS.
- frame_start: high for exactly one cycle, coincident with the first cycle col_sel = 1 (bit 0).
  - The first frame after reset asserts frame_start SCAN_DIV+1 cycles after rst_n deasserts.
- Frame counter: counts frame wraps (col_idx COLS-1 -> 0) from 0 to SCROLL_FRAMES-1. At terminal it generates a scroll tick and returns to 0. It runs in every mode.
- mode is sampled only at the scroll tick; mid-step mode changes have no effect until the next tick. Action at the tick:
  - 01: offset+1, MSG_COLS-1 wraps to 0.
  - 10: offset-1, 0 wraps to MSG_COLS-1.
  - 00 and 11: offset held.
- Offset is updated at the frame boundary only, so a frame never shows a mix of two offsets.
- Blank (mode 11): row=0 and col_sel=0 from the cycle after mode becomes 11. Scanning, frame_start and the frame counter continue. Output resumes from the cycle after mode leaves 11.
- Writes: wr_en synchronous, takes effect at the clock edge.
  - A read of the same column in the same cycle returns the old data; the new data appears at that column's next refresh.
  - Writes are accepted in all modes.
  - wr_addr >= MSG_COLS is ignored.
- Reset asserted mid-frame or mid-step: all state returns to reset values immediately; the buffer contents are lost.

Optional Feature:
- Macro: LED_MATRIX_SCROLLER_BLINK_EN.
- When defined:
  - Adds input blink (1 bit) and parameter BLINK_FRAMES (default 25).
  - A blink phase flag toggles every BLINK_FRAMES frames and resets to 0 (visible).
  - While blink=1 and phase=1, row is forced to 0; col_sel continues scanning.
  - When blink=0, the phase counter still runs but has no effect on the outputs.
- When not defined: no blink port or logic; behaviour is exactly as above.

Test Plan:
- Reset and scan, with ROWS=5, COLS=7, MSG_COLS=16, SCAN_DIV=4, mode=00:
  - Release rst_n -> col_sel steps 0000001, 0000010, ..., 1000000 and wraps, changing every 4 cycles.
  - frame_start pulses once per 28 cycles, aligned with col_sel=0000001.
- Load and hold: write buf[k] = k[4:0] for k=0..15 -> row sequence per frame is 0,1,2,3,4,5,6; offset stays 0.
- Scroll left with wrap, SCROLL_FRAMES=2, mode=01:
  - offset goes 0, 1, 2, ... every 2 frames; after 16 steps it is back to 0.
  - At offset=12, row sequence is 12,13,14,15,0,1,2.
- Scroll right from reset, mode=10 -> first step gives offset=15; row sequence 15,0,1,2,3,4,5.
- Blank and mode-change timing:
  - mode=11 mid-frame -> row=0 and col_sel=0 next cycle; frame_start still pulses every 28 cycles; offset unchanged.
  - Switching 01->00 one cycle before a scroll tick -> offset does not advance.
- Write collision and async reset:
  - Write buf[3]=5'b10101 in the cycle row shows buf[3] -> old value shown; new value shown on the next frame.
  - Assert rst_n low mid-column -> all outputs 0 in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/led_matrix_scroller.sv
// led_matrix_scroller: scrolling message viewer for a ROWS x COLS column-scanned LED matrix.
// The message lives in a writable MSG_COLS-deep column buffer. A COLS-wide window of it is
// scanned onto the panel. The window scrolls left or right with wrap-around once every
// SCROLL_FRAMES frames; it can also hold or blank.
// Optional build macro: LED_MATRIX_SCROLLER_BLINK_EN adds a blink input and the BLINK_FRAMES
// parameter. While blink is set, the row drive is gated off on alternate BLINK_FRAMES-frame periods.
module led_matrix_scroller #(
    parameter int ROWS          = 5,
    parameter int COLS          = 7,
    parameter int MSG_COLS      = 16,
    parameter int SCAN_DIV      = 1000,
    parameter int SCROLL_FRAMES = 50
`ifdef LED_MATRIX_SCROLLER_BLINK_EN
    ,
    parameter int BLINK_FRAMES  = 25
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  mode,
    input  logic                        wr_en,
    input  logic [$clog2(MSG_COLS)-1:0] wr_addr,
    input  logic [ROWS-1:0]             wr_data,
`ifdef LED_MATRIX_SCROLLER_BLINK_EN
    input  logic                        blink,
`endif
    output logic [ROWS-1:0]             row,
    output logic [COLS-1:0]             col_sel,
    output logic                        frame_start,
    output logic [$clog2(MSG_COLS)-1:0] offset
);

    localparam int AW = $clog2(MSG_COLS);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(SCROLL_FRAMES - 1);
    localparam logic [AW-1:0] MSG_LAST  = AW'(MSG_COLS - 1);
    localparam logic [AW:0]   MSG_SIZE  = (AW + 1)'(MSG_COLS);

    typedef enum logic [1:0] {
        M_HOLD  = 2'b00,
        M_LEFT  = 2'b01,
        M_RIGHT = 2'b10,
        M_BLANK = 2'b11
    } mode_t;

    logic [ROWS-1:0] mbuf [MSG_COLS];

    logic [SW-1:0]   scan_cnt;
    logic [CW-1:0]   col_idx;
    logic            started;     // set by the first terminal count; the display stays dark until then
    logic            col_upd;     // one cycle after col_idx has taken a new value
    logic [FW-1:0]   frame_cnt;
    logic [ROWS-1:0] row_hold;    // pattern latched when the column was entered

    logic            scan_term;
    logic            frame_wrap;
    logic            blank;
    logic            row_mask;
    logic [AW:0]     rsum;
    logic [AW-1:0]   raddr;
    logic            wr_ok;

    assign scan_term  = (scan_cnt == SCAN_LAST);
    assign frame_wrap = scan_term && started && (col_idx == COL_LAST);
    assign blank      = (mode_t'(mode) == M_BLANK);
    assign wr_ok      = wr_en && ({1'b0, wr_addr} < MSG_SIZE);

    // Buffer column for the active display column: add, then fold back once (no divider needed)
    always_comb begin
        rsum  = {1'b0, offset} + (AW + 1)'(col_idx);
        raddr = (rsum >= MSG_SIZE) ? AW'(rsum - MSG_SIZE) : rsum[AW-1:0];
    end

    // Message buffer: synchronous write, cleared by reset; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_COLS; i++) mbuf[i] <= '0;
        end else if (wr_ok) begin
            mbuf[wr_addr] <= wr_data;
        end
    end

    // Column prescaler and column index; the first terminal count arms the display at column 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            col_idx  <= '0;
            started  <= 1'b0;
            col_upd  <= 1'b0;
        end else begin
            col_upd <= scan_term;
            if (scan_term) begin
                scan_cnt <= '0;
                if (!started)                 started <= 1'b1;
                else if (col_idx == COL_LAST) col_idx <= '0;
                else                          col_idx <= col_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // Frame counter and scroll offset; offset moves only on the frame wrap so a frame is never mixed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            offset    <= '0;
        end else if (frame_wrap) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt <= '0;
                case (mode_t'(mode))
                    M_LEFT:  offset <= (offset == MSG_LAST) ? '0 : offset + 1'b1;
                    M_RIGHT: offset <= (offset == '0) ? MSG_LAST : offset - 1'b1;
                    default: offset <= offset;
                endcase
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

`ifdef LED_MATRIX_SCROLLER_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Blink phase toggles every BLINK_FRAMES frames; it free-runs whether or not blink is requested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_wrap) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign row_mask = blink && blink_phase;
`else
    assign row_mask = 1'b0;
`endif

    // Registered panel drive; row is sampled from the buffer only on column entry so a
    // mid-dwell write shows up at that column's next refresh, and blank gates both buses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row         <= '0;
            col_sel     <= '0;
            frame_start <= 1'b0;
            row_hold    <= '0;
        end else begin
            frame_start <= col_upd && (col_idx == '0);
            if (col_upd) row_hold <= mbuf[raddr];
            if (started && !blank) begin
                col_sel <= COLS'(1) << col_idx;
                if (row_mask)     row <= '0;
                else if (col_upd) row <= mbuf[raddr];
                else              row <= row_hold;
            end else begin
                col_sel <= '0;
                row     <= '0;
            end
        end
    end

endmodule
